// File: rtl/idwt_pkg.sv
// Shared constants for the Haar DWT/IDWT stages: width defaults, FSM states, saturation limits.
package idwt_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_e;

  function automatic int coef_w(input int w);
    return w + 1;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/idwt_sat_clip.sv
// Clips a (DATA_W+2)-bit signed sum into the signed DATA_W-bit range and flags clipping.
module sat_clip
  import idwt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W+1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     sat
);

  localparam logic signed [DATA_W+1:0] MAXV = (DATA_W+2)'(sat_max(DATA_W));
  localparam logic signed [DATA_W+1:0] MINV = (DATA_W+2)'(sat_min(DATA_W));

  always_comb begin
    dout = din[DATA_W-1:0];
    sat  = 1'b0;
    if (din > MAXV) begin
      dout = MAXV[DATA_W-1:0];
      sat  = 1'b1;
    end else if (din < MINV) begin
      dout = MINV[DATA_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/idwt.sv
// Inverse single-level Haar stage: one coefficient pair in, two saturated samples out serially.
// Optional macro IDWT_LSB_RESTORE_EN adds lsb_parity to restore the LSB dropped by the forward stage.
module idwt
  import idwt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [coef_w(DATA_W)-1:0] average,
  input  logic signed [coef_w(DATA_W)-1:0] difference,
`ifdef IDWT_LSB_RESTORE_EN
  input  logic                         lsb_parity,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W-1:0]     sample,
  output logic                         out_last,
  output logic                         out_sat
);

  state_e state_q, state_d;
  logic signed [DATA_W-1:0] reg_a_q, reg_b_q, clip_a, clip_b;
  logic sat_a_q, sat_b_q, sat_a, sat_b;
  logic load;
  logic signed [DATA_W+1:0] ext_avg, ext_diff, s_a, s_b;

  assign ext_avg  = {average[DATA_W], average};
  assign ext_diff = {difference[DATA_W], difference};
`ifdef IDWT_LSB_RESTORE_EN
  assign s_a = ext_avg + ext_diff + {{(DATA_W+1){1'b0}}, lsb_parity};
`else
  assign s_a = ext_avg + ext_diff;
`endif
  assign s_b = ext_avg - ext_diff;

  sat_clip #(.DATA_W(DATA_W)) u_clip_a (.din(s_a), .dout(clip_a), .sat(sat_a));
  sat_clip #(.DATA_W(DATA_W)) u_clip_b (.din(s_b), .dout(clip_b), .sat(sat_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      reg_a_q <= '0;
      reg_b_q <= '0;
      sat_a_q <= 1'b0;
      sat_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        reg_a_q <= clip_a;
        reg_b_q <= clip_b;
        sat_a_q <= sat_a;
        sat_b_q <= sat_b;
      end
    end
  end

  // Outputs decode from state/registers only, so in_valid never reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    sample    = '0;
    out_sat   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = EMIT_A;
        end
      end
      EMIT_A: begin
        out_valid = 1'b1;
        sample    = reg_a_q;
        out_sat   = sat_a_q;
        if (out_ready) state_d = EMIT_B;
      end
      EMIT_B: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        sample    = reg_b_q;
        out_sat   = sat_b_q;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = EMIT_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_idwt.sv
// Scoreboard bench for idwt: driver pushes expected samples at acceptance, monitor pops on transfer.
module tb_idwt;

  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_sat;
  logic signed [8:0] average, difference;
  logic signed [7:0] sample;
`ifdef IDWT_LSB_RESTORE_EN
  logic lsb_parity;
`endif

  idwt #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .average(average), .difference(difference),
`ifdef IDWT_LSB_RESTORE_EN
    .lsb_parity(lsb_parity),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sample(sample),
    .out_last(out_last), .out_sat(out_sat)
  );

  typedef struct packed {
    logic signed [7:0] smp;
    logic              last;
    logic              sat;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   pop_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every transfer (valid && ready seen between edges) is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      vectors++;
      pop_cyc.push_back(cyc);
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sample=%0d last=%0b sat=%0b, expected no output",
                 sample, out_last, out_sat);
      end else begin
        e = q.pop_front();
        if (sample !== e.smp || out_last !== e.last || out_sat !== e.sat) begin
          errors++;
          $display("FAIL out_sample: got sample=%0d last=%0b sat=%0b, expected sample=%0d last=%0b sat=%0b",
                   sample, out_last, out_sat, e.smp, e.last, e.sat);
        end
      end
    end
  end

  task automatic send(input logic signed [8:0] a, input logic signed [8:0] d, input logic p,
                      input logic signed [7:0] ea, input logic sa,
                      input logic signed [7:0] eb, input logic sb);
    bit ok = 0;
    average    = a;
    difference = d;
`ifdef IDWT_LSB_RESTORE_EN
    lsb_parity = p;
`else
    if (p) $display("note: lsb_parity ignored in this build");
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 64 cycles");
    end else begin
      q.push_back('{smp: ea, last: 1'b0, sat: sa});
      q.push_back('{smp: eb, last: 1'b1, sat: sb});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1;
    end
    chk("drain_queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; average = '0; difference = '0;
`ifdef IDWT_LSB_RESTORE_EN
    lsb_parity = 1'b0;
`endif
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic, lossy/negative, saturation, extremes
    send(9'sd5, 9'sd2, 1'b0, 8'sd7, 1'b0, 8'sd3, 1'b0);
    drain();
    chk("basic_back_idle_in_ready", in_ready, 1);
    send(-9'sd2, -9'sd6, 1'b0, -8'sd8, 1'b0, 8'sd4, 1'b0);
`ifdef IDWT_LSB_RESTORE_EN
    send(-9'sd2, -9'sd6, 1'b1, -8'sd7, 1'b0, 8'sd4, 1'b0);
    send(9'sd5, 9'sd2, 1'b1, 8'sd8, 1'b0, 8'sd3, 1'b0);
`endif
    send(9'sd127, 9'sd127, 1'b0, 8'sd127, 1'b1, 8'sd0, 1'b0);
    send(-9'sd128, 9'sd127, 1'b0, -8'sd1, 1'b0, -8'sd128, 1'b1);
    send(9'sd255, 9'sd255, 1'b0, 8'sd127, 1'b1, 8'sd0, 1'b0);
    send(-9'sd256, 9'sd255, 1'b0, -8'sd1, 1'b0, -8'sd128, 1'b1);
    send(-9'sd256, -9'sd256, 1'b0, -8'sd128, 1'b1, 8'sd0, 1'b0);
    drain();

    // backpressure: hold in both emit states while a new pair waits upstream
    out_ready = 1'b0;
    send(9'sd5, 9'sd2, 1'b0, 8'sd7, 1'b0, 8'sd3, 1'b0);
    fork
      send(9'sd40, 9'sd10, 1'b0, 8'sd50, 1'b0, 8'sd30, 1'b0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_a_valid", out_valid, 1);
          chk("bp_a_sample", sample, 7);
          chk("bp_a_last", out_last, 0);
          chk("bp_a_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_b_valid", out_valid, 1);
          chk("bp_b_sample", sample, 3);
          chk("bp_b_last", out_last, 1);
          chk("bp_b_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // streaming: four pairs back to back, eight samples without bubbles
    base = pop_cyc.size();
    send(9'sd10, 9'sd3, 1'b0, 8'sd13, 1'b0, 8'sd7, 1'b0);
    send(-9'sd20, 9'sd5, 1'b0, -8'sd15, 1'b0, -8'sd25, 1'b0);
    send(9'sd0, 9'sd0, 1'b0, 8'sd0, 1'b0, 8'sd0, 1'b0);
    send(9'sd50, -9'sd30, 1'b0, 8'sd20, 1'b0, 8'sd80, 1'b0);
    drain();
    chk("stream_sample_count", pop_cyc.size() - base, 8);
    if (pop_cyc.size() - base == 8)
      chk("stream_no_bubble_span", pop_cyc[base+7] - pop_cyc[base], 7);

    // asynchronous reset in EMIT_A discards the held pair
    out_ready = 1'b0;
    send(9'sd60, 9'sd4, 1'b0, 8'sd64, 1'b0, 8'sd56, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sample", sample, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    send(-9'sd3, 9'sd1, 1'b0, -8'sd2, 1'b0, -8'sd4, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
